uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin, packet-locked arbiter that shares the single `async_transmitter` among `NUM_REQ` byte-stream requesters (e.g. injection-status reporter, command echo, error logger). It grants one requester at a time and holds the grant until that requester's `last` byte has left the transmitter, so packets never interleave on TxD. It drives `async_transmitter`'s `TxD_start`/`TxD_data`, watches `TxD_busy`, and sits between the requesters and the UART.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 65535: idle-owner timeout in clk cycles, ≥2; only used with `UART_ARB_TIMEOUT_EN`.
- `clk`  in  1  system clock, the same clock as `async_transmitter`.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester byte valid.
- `req_data`  in  NUM_REQ*8  byte i at [8i+7:8i].
- `req_last`  in  NUM_REQ  byte is the final byte of its packet.
- `req_ready`  out  NUM_REQ  byte accepted this cycle (transfer = valid & ready).
- `grant`  out  NUM_REQ  one-hot owner, or 0 when idle.
- `tx_start`  out  1  one-cycle pulse to `TxD_start`.
- `tx_data`  out  8  to `TxD_data`; held stable while `tx_start` is high.
- `tx_busy`  in  1  from `TxD_busy`.
- `timeout_err`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- States: IDLE, HOLD, START, DRAIN.
- IDLE:
  - `grant`=0.
  - If any `req_valid` is high, pick the first set bit searching from `ptr` upward with wrap.
  - Load the one-hot `grant` and go to HOLD.
- HOLD:
  - `req_ready[owner]` = ~`tx_busy` (combinational). All other `req_ready` are 0.
  - On transfer: register `tx_data`=byte, `last_q`=`req_last[owner]`, then go to START.
- START:
  - `tx_start`=1 for this cycle only. Go to DRAIN.
- DRAIN:
  - Wait for `tx_busy`=0.
  - Then if `last_q` is set: `ptr`=(owner+1) mod NUM_REQ, `grant`=0, go to IDLE.
  - Otherwise return to HOLD.
- `ptr` advances only on packet completion or timeout, never on a single byte.
- `req_valid` from non-owners is ignored while a grant is held.
- A new arbitration never happens in the same cycle as a release. IDLE always lasts at least one cycle.
- Reset mid-operation:
  - State→IDLE, `grant`=0, `ptr`=0, `tx_start`=0.
  - A frame already in the transmitter finishes on its own.
  - The next byte waits for `tx_busy`=0 via HOLD.
- Requester contract: `req_data`/`req_last` stable while `req_valid` is high and not yet accepted.

## Timing
- Reset values: `grant`=0, `req_ready`=0, `tx_start`=0, `tx_data`=8'h00, `timeout_err`=0; internally `ptr`=0, `last_q`=0.
- Cycle T: request seen in IDLE. T+1: `grant` valid, state HOLD, `req_ready` high if `tx_busy`=0.
- Transfer at cycle A: `tx_start`=1 at A+1. `tx_busy` is high from A+2 (transmitter leaves its idle state).
- Next byte can be accepted in the first cycle DRAIN sees `tx_busy`=0, plus one cycle for HOLD.
- Byte-to-byte overhead: 3 clk beyond the transmitter frame.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A counter clears on any transfer and on entry to HOLD, and increments each HOLD cycle with `req_valid[owner]`=0.
  - At `TIMEOUT_CYCLES`: pulse `timeout_err`, set `ptr`=owner+1, `grant`=0, go to IDLE. A packet in progress is abandoned.
- Not defined: no counter. The grant is held indefinitely until `last`. `timeout_err` is tied 0.

## Structure
- Package `uart_arb_pkg`: state enum (IDLE/HOLD/START/DRAIN), `UART_ARB_MAX_REQ`=8, and `NUM_REQ`/`TIMEOUT_CYCLES` defaults.
- One sub-module, `uart_rr_picker`: combinational rotate / priority-find / unrotate from `req_valid` and `ptr` to a one-hot winner.

## Test plan
- Single packet: req0 sends 8'h41, 8'h42 (last) → `tx_data` 41 then 42, one `tx_start` each; `grant`=4'b0001 throughout; `ptr`=1 after.
- Contention: req1 and req3 both valid with 3-byte packets at `ptr`=0 → all of req1's bytes first, then all of req3's. No interleave. `ptr`=0 at end.
- Fairness: all four requesters continuously sending 1-byte packets → grants cycle 0,1,2,3,0; each `req_ready` pulse count equals the others ±1.
- Busy gating: hold `tx_busy`=1 for 50 cycles in HOLD → `req_ready` stays 0, no `tx_start`. Release → transfer in the same cycle, `tx_start` the next.
- Reset mid-packet: assert `rst` while in DRAIN with `tx_busy`=1 → next cycle `grant`=0, `tx_start`=0. After reset, no `tx_start` until `tx_busy`=0.
- Timeout (macro on, `TIMEOUT_CYCLES`=16): req2 sends a non-last byte then drops valid → `timeout_err` pulses once 16 HOLD cycles later; `grant`=0; `ptr`=3. With the macro off, `grant` stays at req2.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// The optional idle-owner timeout is enabled by defining UART_ARB_TIMEOUT_EN.
package uart_arb_pkg;

    localparam int UART_ARB_MAX_REQ     = 8;
    localparam int UART_ARB_DEF_NUM_REQ = 4;
    localparam int UART_ARB_DEF_TIMEOUT = 65535;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        START = 2'd2,
        DRAIN = 2'd3
    } arb_state_e;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: rotate requests by ptr, take the lowest set
// bit, rotate back to a one-hot winner (zero when no request is pending).
module uart_rr_picker
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = UART_ARB_DEF_NUM_REQ,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] win_o
);

    logic [NUM_REQ-1:0] rot;
    logic [NUM_REQ-1:0] rot_win;

    // rot[k] is the request sitting k positions above ptr (with wrap)
    genvar gi;
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
        logic bit_r;
        always_comb begin
            bit_r = 1'b0;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (((gi + int'(ptr_i)) % NUM_REQ) == j) begin
                    bit_r = req_i[j];
                end
            end
        end
        assign rot[gi] = bit_r;
    end

    always_comb begin
        logic found;
        found   = 1'b0;
        rot_win = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (rot[k] && !found) begin
                rot_win[k] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unrot
        logic bit_w;
        always_comb begin
            bit_w = 1'b0;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (((k + int'(ptr_i)) % NUM_REQ) == gi) begin
                    bit_w = rot_win[k];
                end
            end
        end
        assign win_o[gi] = bit_w;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter in front of a single async_transmitter.
// Define UART_ARB_TIMEOUT_EN to revoke a grant whose owner stays idle too long.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = UART_ARB_DEF_NUM_REQ,
    parameter int TIMEOUT_CYCLES = UART_ARB_DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 timeout_err
);

    localparam int PW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > UART_ARB_MAX_REQ || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("uart_tx_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
    end

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               last_q, last_d;

    logic [NUM_REQ-1:0] pick;
    logic [PW-1:0]      owner_idx;
    logic [PW-1:0]      owner_next;
    logic [7:0]         req_byte [NUM_REQ];
    logic [7:0]         cur_byte;
    logic               cur_last;
    logic               owner_valid;
    logic               xfer;
    logic               timeout_hit;

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_picker (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .win_o (pick)
    );

    genvar gi;
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
        assign req_byte[gi] = req_data[gi*8 +: 8];
    end

    always_comb begin
        owner_idx = '0;
        cur_byte  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                owner_idx = PW'(i);
                cur_byte  = cur_byte | req_byte[i];
            end
        end
    end

    assign owner_next  = (owner_idx == PW'(NUM_REQ - 1)) ? '0 : owner_idx + PW'(1);
    assign cur_last    = |(req_last & grant_q);
    assign owner_valid = |(req_valid & grant_q);
    assign req_ready   = (state_q == HOLD && !tx_busy) ? grant_q : '0;
    assign xfer        = |(req_valid & req_ready);

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] idle_cnt_q, idle_cnt_d;
    logic          timeout_q;

    // Held at zero outside HOLD, so every entry into HOLD starts a fresh count
    always_comb begin
        idle_cnt_d  = idle_cnt_q;
        timeout_hit = 1'b0;
        if (state_q != HOLD || xfer) begin
            idle_cnt_d = '0;
        end else if (!owner_valid) begin
            idle_cnt_d  = idle_cnt_q + CW'(1);
            timeout_hit = (idle_cnt_d == CW'(TIMEOUT_CYCLES));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            timeout_q  <= timeout_hit;
        end
    end

    assign timeout_err = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        tx_data_d = tx_data_q;
        last_d    = last_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d = pick;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (xfer) begin
                    tx_data_d = cur_byte;
                    last_d    = cur_last;
                    state_d   = START;
                end else if (timeout_hit) begin
                    ptr_d   = owner_next;
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            START: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        ptr_d   = owner_next;
                        grant_d = '0;
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            tx_data_q <= 8'h00;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            tx_data_q <= tx_data_d;
            last_q    <= last_d;
        end
    end

    assign grant    = grant_q;
    assign tx_start = (state_q == START);
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small transmitter busy model.
// Timeout expectations follow UART_ARB_TIMEOUT_EN as seen by this compile.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int FRAME   = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 timeout_err;

    logic force_busy;
    int   busy_cnt = 0;

    int checks   = 0;
    int failures = 0;

    logic [8:0]  src_q [NUM_REQ][$];
    logic [11:0] log_q [$];
    logic [11:0] exp_q [$];
    int          xfer_cnt [NUM_REQ];

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .grant       (grant),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy from the cycle after it samples tx_start, for FRAME cycles
    always @(posedge clk) begin
        if (tx_start) busy_cnt <= FRAME;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = force_busy | (busy_cnt != 0);

    always @(negedge clk) begin
        if (tx_start) begin
            log_q.push_back({grant, tx_data});
            $display("tx byte=%02h grant=%b t=%0t", tx_data, grant, $time);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_tx(input logic [3:0] g, input logic [7:0] d);
        exp_q.push_back({g, d});
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_len"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            chk(tag, {20'h0, log_q[i]}, {20'h0, exp_q[i]});
        end
        log_q.delete();
        exp_q.delete();
    endtask

    // Call at posedge+1; drives queued bytes until all sent and the arbiter is idle
    task automatic run_traffic(input string tag, input int max_cycles);
        int n;
        bit done;
        bit empty;
        logic [NUM_REQ-1:0] xfer;
        n    = 0;
        done = 1'b0;
        while (!done && n < max_cycles) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (src_q[i].size() > 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[i*8 +: 8] = src_q[i][0][7:0];
                    req_last[i]        = src_q[i][0][8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
            @(negedge clk);
            xfer = req_valid & req_ready;
            @(posedge clk);
            #1;
            empty = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (xfer[i]) begin
                    void'(src_q[i].pop_front());
                    xfer_cnt[i]++;
                end
                if (src_q[i].size() > 0) empty = 1'b0;
            end
            n++;
            done = empty && (grant == '0) && !tx_busy;
        end
        req_valid = '0;
        req_last  = '0;
        chk({tag, "_complete"}, {31'h0, done}, 32'h1);
    endtask

    initial begin
        int n;
        int pulses;
        int pulse_at;
        logic [3:0] grant_at;

        rst        = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        req_last   = '0;
        force_busy = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) xfer_cnt[i] = 0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant",   {28'h0, grant},       32'h0);
        chk("rst_ready",   {28'h0, req_ready},   32'h0);
        chk("rst_start",   {31'h0, tx_start},    32'h0);
        chk("rst_data",    {24'h0, tx_data},     32'h00);
        chk("rst_timeout", {31'h0, timeout_err}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single two-byte packet from req0; ptr moves to 1
        src_q[0].push_back(9'h041);
        src_q[0].push_back(9'h142);
        expect_tx(4'b0001, 8'h41);
        expect_tx(4'b0001, 8'h42);
        run_traffic("single", 200);
        check_log("single");

        // Fairness: everyone has two 1-byte packets; starting at ptr=1
        for (int i = 0; i < NUM_REQ; i++) begin
            xfer_cnt[i] = 0;
            src_q[i].push_back({1'b1, 8'h10 + 8'(i)});
            src_q[i].push_back({1'b1, 8'h20 + 8'(i)});
        end
        expect_tx(4'b0010, 8'h11);
        expect_tx(4'b0100, 8'h12);
        expect_tx(4'b1000, 8'h13);
        expect_tx(4'b0001, 8'h10);
        expect_tx(4'b0010, 8'h21);
        expect_tx(4'b0100, 8'h22);
        expect_tx(4'b1000, 8'h23);
        expect_tx(4'b0001, 8'h20);
        run_traffic("fair", 600);
        check_log("fair");
        for (int i = 0; i < NUM_REQ; i++) chk("fair_count", xfer_cnt[i], 2);

        // Contention: req1 and req3 three-byte packets, no interleave; ptr ends at 0
        src_q[1].push_back(9'h011);
        src_q[1].push_back(9'h012);
        src_q[1].push_back(9'h113);
        src_q[3].push_back(9'h031);
        src_q[3].push_back(9'h032);
        src_q[3].push_back(9'h133);
        expect_tx(4'b0010, 8'h11);
        expect_tx(4'b0010, 8'h12);
        expect_tx(4'b0010, 8'h13);
        expect_tx(4'b1000, 8'h31);
        expect_tx(4'b1000, 8'h32);
        expect_tx(4'b1000, 8'h33);
        run_traffic("contend", 600);
        check_log("contend");

        // ptr=0 now, so req0 beats req3
        src_q[0].push_back(9'h101);
        src_q[3].push_back(9'h134);
        expect_tx(4'b0001, 8'h01);
        expect_tx(4'b1000, 8'h34);
        run_traffic("ptr0", 300);
        check_log("ptr0");

        // Busy gating: req2 granted while the transmitter reports busy for 50 cycles
        force_busy         = 1'b1;
        req_valid[2]       = 1'b1;
        req_data[2*8 +: 8] = 8'h55;
        req_last[2]        = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("gate_grant", {28'h0, grant}, 32'b0100);
        for (int k = 0; k < 50; k++) begin
            chk("gate_ready", {28'h0, req_ready}, 32'h0);
            chk("gate_start", {31'h0, tx_start},  32'h0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 force_busy = 1'b0;
        @(negedge clk);
        chk("gate_release_ready", {28'h0, req_ready}, 32'b0100);
        @(posedge clk);
        #1 req_valid = '0;
        req_last = '0;
        @(negedge clk);
        chk("gate_start_next", {31'h0, tx_start}, 32'h1);
        chk("gate_data",       {24'h0, tx_data},  32'h55);
        run_traffic("gate", 100);
        log_q.delete();

        // Reset while DRAIN waits on a busy transmitter
        req_valid[3]       = 1'b1;
        req_data[3*8 +: 8] = 8'h66;
        req_last[3]        = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_start && n < 20);
        chk("rst_mid_started", {31'h0, tx_start}, 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        req_valid = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        req_valid[3]       = 1'b1;
        req_data[3*8 +: 8] = 8'h67;
        req_last[3]        = 1'b1;
        @(negedge clk);
        chk("rst_mid_grant", {28'h0, grant},    32'h0);
        chk("rst_mid_start", {31'h0, tx_start}, 32'h0);
        n = 0;
        while (tx_busy && n < 20) begin
            chk("rst_mid_no_start", {31'h0, tx_start},  32'h0);
            chk("rst_mid_no_ready", {28'h0, req_ready}, 32'h0);
            @(negedge clk);
            n++;
        end
        chk("rst_mid_bound", {31'h0, tx_busy}, 32'h0);
        chk("rst_mid_ready", {28'h0, req_ready}, 32'b1000);
        @(posedge clk);
        #1 req_valid = '0;
        req_last = '0;
        @(negedge clk);
        chk("rst_mid_tx",   {31'h0, tx_start}, 32'h1);
        chk("rst_mid_data", {24'h0, tx_data},  32'h67);
        run_traffic("rst_mid", 100);
        log_q.delete();

        // Idle owner: req2 sends a non-last byte then goes quiet (ptr=0 here)
        req_valid[2]       = 1'b1;
        req_data[2*8 +: 8] = 8'h77;
        req_last[2]        = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_start && n < 20);
        chk("to_started", {31'h0, tx_start}, 32'h1);
        @(posedge clk);
        #1 req_valid = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_busy && n < 30);
        chk("to_busy_bound", {31'h0, tx_busy}, 32'h0);
        // k=0 is the last DRAIN cycle; HOLD occupies k=1..16, revocation shows at k=17
        pulses   = 0;
        pulse_at = -1;
        grant_at = 4'hf;
        for (int k = 0; k < 40; k++) begin
            if (timeout_err) begin
                pulses++;
                if (pulse_at < 0) begin
                    pulse_at = k;
                    grant_at = grant;
                end
            end
            @(negedge clk);
        end
`ifdef UART_ARB_TIMEOUT_EN
        chk("to_pulses",   pulses,           1);
        chk("to_delay",    pulse_at,         17);
        chk("to_grant_at", {28'h0, grant_at}, 32'h0);
        chk("to_grant",    {28'h0, grant},    32'h0);
        @(posedge clk);
        #1;
        expect_tx(4'b0100, 8'h77);
        check_log("to_log");
`else
        chk("to_pulses", pulses,          0);
        chk("to_grant",  {28'h0, grant},  32'b0100);
        @(posedge clk);
        #1;
        src_q[2].push_back(9'h178);
        expect_tx(4'b0100, 8'h77);
        expect_tx(4'b0100, 8'h78);
        run_traffic("to_finish", 100);
        check_log("to_log");
`endif

        // Either way ptr is now 3: req3 goes before req0
        src_q[0].push_back(9'h1a0);
        src_q[3].push_back(9'h1a3);
        expect_tx(4'b1000, 8'ha3);
        expect_tx(4'b0001, 8'ha0);
        run_traffic("ptr3", 300);
        check_log("ptr3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
